// File: rtl/chopper_sequencer.sv
// Purpose : fixed-off-time chopper sequencer for a bridge driver (IDLE -> BLANK -> DRIVE -> DECAY -> BLANK ...).
// Latency : drive_on/decay/blanking/state decode directly from the state register; cycle_done/maxon_hit
//           are registered pulses that coincide with the first cycle of the new phase.
// Backpressure: none; enable=0 forces IDLE on the next edge, reset forces IDLE asynchronously.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high
//   enable       1 = run chopper cycles, 0 = return to IDLE with the bridge off
//   overcurrent  current-comparator trip, already synchronous to clk
//   blank_time   blanking length after drive turn-on (phase lasts blank_time+1 cycles)
//   off_time     decay length after a trip (phase lasts off_time+1 cycles)
//   drive_on     bridge drive active (BLANK or DRIVE)
//   decay        high in DECAY
//   blanking     high in BLANK
//   state        IDLE=0, BLANK=1, DRIVE=2, DECAY=3
//   cycle_done   one-cycle pulse on the first BLANK cycle after a DECAY
//
// Optional feature, macro CHOPPER_MAXON_EN:
//   max_on_time  maximum on time measured from BLANK entry, 0 disables the limit
//   maxon_hit    one-cycle pulse on the first DECAY cycle when the limit, not a trip, ended DRIVE
module chopper_sequencer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             overcurrent,
  input  logic [WIDTH-1:0] blank_time,
  input  logic [WIDTH-1:0] off_time,
`ifdef CHOPPER_MAXON_EN
  input  logic [WIDTH-1:0] max_on_time,
  output logic             maxon_hit,
`endif
  output logic             drive_on,
  output logic             decay,
  output logic             blanking,
  output logic [1:0]       state,
  output logic             cycle_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2,
    S_DECAY = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_cycle_done;

  logic             w_cnt_zero;
  logic [WIDTH-1:0] w_cnt_dec;
  logic             w_blank_entry;
  logic             w_maxon_trip;

  // Phase counter: loaded on phase entry, counts down and parks at zero.
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_dec  = w_cnt_zero ? '0 : (r_cnt - WIDTH'(1));

  // Every way into BLANK: from IDLE, or from DECAY once its counter has run out.
  assign w_blank_entry = enable &&
                         ((r_state == S_IDLE) || ((r_state == S_DECAY) && w_cnt_zero));

`ifdef CHOPPER_MAXON_EN
  logic [WIDTH-1:0] r_maxon_cnt;
  logic             r_maxon_arm;
  logic             r_maxon_hit;

  // The limit is armed per cycle from the value captured at BLANK entry, so a
  // mid-cycle change of max_on_time only takes effect on the next cycle.
  assign w_maxon_trip = r_maxon_arm && (r_maxon_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_maxon_cnt <= '0;
      r_maxon_arm <= 1'b0;
      r_maxon_hit <= 1'b0;
    end else begin
      r_maxon_hit <= 1'b0;
      if (!enable) begin
        r_maxon_cnt <= '0;
        r_maxon_arm <= 1'b0;
      end else if (w_blank_entry) begin
        r_maxon_cnt <= max_on_time;
        r_maxon_arm <= (max_on_time != '0);
      end else if ((r_state == S_BLANK) || (r_state == S_DRIVE)) begin
        if (r_maxon_cnt != '0) begin
          r_maxon_cnt <= r_maxon_cnt - WIDTH'(1);
        end
        // Pulse only when the limit is what ends DRIVE on this edge.
        if ((r_state == S_DRIVE) && w_maxon_trip) begin
          r_maxon_hit <= 1'b1;
        end
      end
    end
  end

  assign maxon_hit = r_maxon_hit;
`else
  // Without the limit, DRIVE ends on overcurrent only.
  assign w_maxon_trip = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_cycle_done <= 1'b0;
      if (!enable) begin
        // enable low wins over every phase, including a DECAY about to finish.
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_BLANK;
            r_cnt   <= blank_time;
          end
          S_BLANK: begin
            // overcurrent is deliberately ignored here: turn-on spikes are blanked.
            if (w_cnt_zero) begin
              r_state <= S_DRIVE;
            end
            r_cnt <= w_cnt_dec;
          end
          S_DRIVE: begin
            if (overcurrent || w_maxon_trip) begin
              r_state <= S_DECAY;
              r_cnt   <= off_time;
            end else begin
              r_cnt <= w_cnt_dec;
            end
          end
          S_DECAY: begin
            if (w_cnt_zero) begin
              r_state      <= S_BLANK;
              r_cnt        <= blank_time;
              r_cycle_done <= 1'b1;
            end else begin
              r_cnt <= w_cnt_dec;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Pure decodes of the state register so reset clears them without waiting for an edge.
  assign state      = r_state;
  assign drive_on   = (r_state == S_BLANK) || (r_state == S_DRIVE);
  assign decay      = (r_state == S_DECAY);
  assign blanking   = (r_state == S_BLANK);
  assign cycle_done = r_cycle_done;

endmodule

// File: doc/chopper_sequencer.md
CHOPPER_SEQUENCER -- requirements
Module: chopper_sequencer

Interface
REQ-001 Parameter WIDTH, default 10: width of all time fields and internal counters, in clk cycles.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  high = run chopper cycles; low = stop and hold the bridge off.
REQ-005 overcurrent  input  1  current-comparator trip, already synchronised to clk.
REQ-006 blank_time  input  WIDTH  blanking duration after drive turn-on.
REQ-007 off_time  input  WIDTH  decay (off) duration after a trip.
REQ-008 drive_on  output  1  bridge drive active; high in BLANK and DRIVE.
REQ-009 decay  output  1  high in DECAY only.
REQ-010 blanking  output  1  high in BLANK only.
REQ-011 state  output  2  current state encoding.
REQ-012 cycle_done  output  1  one-cycle pulse on each DECAY->BLANK transition.

Function
REQ-013 The block SHALL implement states IDLE=0, BLANK=1, DRIVE=2, DECAY=3; outputs decode from the state register only, with no added latency.
REQ-014 The block SHALL contain one WIDTH-bit down-counter: loaded on phase entry, decremented by 1 each cycle while >0, saturating at 0.
REQ-015 IDLE with enable=1 SHALL go to BLANK next cycle, loading counter=blank_time.
REQ-016 BLANK SHALL ignore overcurrent and go to DRIVE on the cycle the counter reads 0; blank_time=0 gives exactly one BLANK cycle.
REQ-017 DRIVE SHALL stay until overcurrent=1 is sampled, then go to DECAY, loading counter=off_time.
REQ-018 DECAY SHALL go to BLANK when the counter reads 0, loading counter=blank_time and asserting cycle_done for that transition cycle; off_time=0 gives one DECAY cycle.
REQ-019 Time inputs SHALL be sampled only at load; changes mid-phase have no effect on the current phase.
REQ-020 enable=0 SHALL take priority in every state: next cycle is IDLE, counter=0, cycle_done=0.
REQ-021 overcurrent held high continuously SHALL yield repeated BLANK->DRIVE(1 cycle)->DECAY cycles; it shall never skip BLANK.

Reset
REQ-022 reset=1 SHALL asynchronously force state=IDLE, counter(s)=0, drive_on=0, decay=0, blanking=0, cycle_done=0, maxon_hit=0.
REQ-023 Reset asserted mid-phase SHALL abort that phase; after release the block restarts from IDLE per REQ-015.

Configuration
REQ-024 Macro CHOPPER_MAXON_EN defined SHALL add input max_on_time (WIDTH) and output maxon_hit (1).
REQ-025 With CHOPPER_MAXON_EN, a second WIDTH-bit counter SHALL load max_on_time on BLANK entry and decrement, saturating, through BLANK and DRIVE.
REQ-026 With CHOPPER_MAXON_EN, in DRIVE with that counter at 0 and max_on_time!=0, the block SHALL enter DECAY as for a trip and pulse maxon_hit for one cycle; max_on_time=0 disables the limit.
REQ-027 Without CHOPPER_MAXON_EN, neither port nor the second counter SHALL exist, and DRIVE exits only on overcurrent.

Verification
REQ-028 reset release, enable=1 at cycle 0, blank_time=3 -> state=BLANK at cycles 1-4, DRIVE at cycle 5, drive_on=1 throughout.
REQ-029 DRIVE, overcurrent pulse at cycle N, off_time=5 -> decay=1 at cycles N+1..N+6, cycle_done=1 at the N+6 transition, BLANK at N+7.
REQ-030 overcurrent=1 during BLANK with blank_time=4 -> no DECAY entry until DRIVE; overcurrent held high -> a periodic BLANK/DRIVE/DECAY pattern of blank_time+off_time+3 cycles.
REQ-031 enable dropped mid-DECAY -> IDLE next cycle, all outputs 0, no cycle_done.
REQ-032 reset asserted between clock edges during DRIVE -> drive_on=0 immediately, before the next edge.
REQ-033 CHOPPER_MAXON_EN, max_on_time=8, blank_time=2, overcurrent=0 -> DECAY entered 9 cycles after BLANK entry with maxon_hit=1 pulse; max_on_time=0 -> DRIVE held indefinitely.
